// File: rtl/decode_pkg.sv
// Shared decode/execute definitions: opcodes, ID_EX bundle layout, helpers.
package decode_pkg;

  localparam logic [3:0] OP_ZERO = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_MOV  = 4'hB;
  localparam logic [3:0] OP_ADI  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // ID_EX bundle layout; execute slices the bundle with these same offsets.
  localparam int ID_EX_W         = 181;
  localparam int ID_EX_PC_LSB    = 0;
  localparam int ID_EX_RS_LSB    = 32;
  localparam int ID_EX_RT_LSB    = 64;
  localparam int ID_EX_RD_LSB    = 96;
  localparam int ID_EX_IMM_LSB   = 112;
  localparam int ID_EX_OP_LSB    = 160;
  localparam int ID_EX_OP_W      = 16;
  localparam int ID_EX_SHAMT_LSB = 176;

  // Bundle driven whenever no instruction is issued: everything zero, op NOP.
  localparam logic [ID_EX_W-1:0] ID_EX_IDLE = {5'd0, 16'h000F, 160'd0};

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } dec_state_e;

  // True when the instruction updates a real (non-r0) destination register.
  function automatic logic is_writer(input logic [3:0] op, input logic [4:0] rd);
    logic wr_s;
    case (op)
      OP_ADD, OP_SUB, OP_LDI, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR,
      OP_MOV, OP_ADI, OP_MUL: wr_s = 1'b1;
      default:                wr_s = 1'b0;
    endcase
    return wr_s && (rd != 5'd0);
  endfunction

  // Assemble an ID_EX bundle; unused gaps stay zero.
  function automatic logic [ID_EX_W-1:0] pack_id_ex(
    input logic [31:0] pc,
    input logic [31:0] rs_val,
    input logic [31:0] rt_val,
    input logic [4:0]  rd,
    input logic [15:0] imm16,
    input logic [3:0]  op,
    input logic [4:0]  shamt
  );
    logic [ID_EX_W-1:0] b_s;
    b_s = {ID_EX_W{1'b0}};
    b_s[ID_EX_PC_LSB    +: 32]         = pc;
    b_s[ID_EX_RS_LSB    +: 32]         = rs_val;
    b_s[ID_EX_RT_LSB    +: 32]         = rt_val;
    b_s[ID_EX_RD_LSB    +: 5]          = rd;
    b_s[ID_EX_IMM_LSB   +: 16]         = imm16;
    b_s[ID_EX_OP_LSB    +: ID_EX_OP_W] = {12'h000, op};
    b_s[ID_EX_SHAMT_LSB +: 5]          = shamt;
    return b_s;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two async read ports with write-through, one sync write, r0 = 0.
module regfile_2r1w #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs_r [REG_COUNT];

  // Register storage; r0 is never written so it stays zero after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Read ports: r0 forced to zero, same-cycle write forwarded.
  always_comb begin
    if (rd_addr_a == 5'd0) begin
      rd_data_a = {DATA_W{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
    if (rd_addr_b == 5'd0) begin
      rd_data_b = {DATA_W{1'b0}};
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode/register-read stage: scoreboard hazard stall, local branch resolve, HLT latch.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_COUNT        = 32,
  parameter int DATA_W           = 32,
  parameter int BNE_CHECK_HAZARD = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [31:0]        if_instr,
  input  logic [31:0]        if_pc,
  output logic               if_ready,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [ID_EX_W-1:0] id_ex,
  output logic               id_valid,
  output logic               branch_taken,
  output logic [31:0]        branch_target,
  output logic               halted
);

  logic [3:0]           op_s;
  logic [3:0]           op_norm_s;
  logic [4:0]           rd_s;
  logic [4:0]           rs_s;
  logic [4:0]           rt_s;
  logic [4:0]           shamt_s;
  logic [15:0]          imm16_s;
  logic [31:0]          target_s;
  logic [DATA_W-1:0]    rs_val_s;
  logic [DATA_W-1:0]    rt_val_s;
  logic [REG_COUNT-1:0] pending_r;   // bit 0 is never set: r0 has no producer
  logic [REG_COUNT-1:0] pend_eff_s;
  logic [REG_COUNT-1:0] pend_next_s;
  logic                 writer_s;
  logic                 src_chk_s;
  logic                 hazard_s;
  logic                 if_ready_s;
  logic                 accept_s;
  dec_state_e           state_r;
  logic [ID_EX_W-1:0]   id_ex_r;
  logic                 id_valid_r;
  logic                 branch_taken_r;
  logic [31:0]          branch_target_r;
  logic                 halted_r;

  assign op_s      = if_instr[31:28];
  assign rd_s      = if_instr[27:23];
  assign rs_s      = if_instr[22:18];
  assign rt_s      = if_instr[17:13];
  assign shamt_s   = if_instr[4:0];
  assign imm16_s   = {{3{if_instr[12]}}, if_instr[12:0]};
  assign op_norm_s = (op_s == OP_ZERO) ? OP_NOP : op_s;
  assign target_s  = if_pc + {{16{imm16_s[15]}}, imm16_s};
  assign writer_s  = is_writer(op_s, rd_s);

  assign if_ready      = if_ready_s;
  assign id_ex         = id_ex_r;
  assign id_valid      = id_valid_r;
  assign branch_taken  = branch_taken_r;
  assign branch_target = branch_target_r;
  assign halted        = halted_r;

  regfile_2r1w #(
    .REG_COUNT (REG_COUNT),
    .DATA_W    (DATA_W)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (rs_s),
    .rd_data_a (rs_val_s),
    .rd_addr_b (rt_s),
    .rd_data_b (rt_val_s)
  );

  // Hazard check against pending bits after this cycle's writeback clear.
  always_comb begin
    pend_eff_s = pending_r;
    if (wb_en) begin
      pend_eff_s[wb_addr] = 1'b0;
    end else begin
      pend_eff_s = pending_r;
    end
    src_chk_s  = (op_s != OP_BNE) || (BNE_CHECK_HAZARD != 32'sd0);
    hazard_s   = (src_chk_s && (pend_eff_s[rs_s] || pend_eff_s[rt_s])) ||
                 (writer_s && pend_eff_s[rd_s]);
    if_ready_s = (state_r == ST_RUN) && !hazard_s && !branch_taken_r && !reset;
    accept_s   = if_valid && if_ready_s;
  end

  // Scoreboard next state: a same-cycle issue re-sets a bit that writeback clears.
  always_comb begin
    pend_next_s = pend_eff_s;
    if (accept_s && writer_s) begin
      pend_next_s[rd_s] = 1'b1;
    end else begin
      pend_next_s = pend_eff_s;
    end
    pend_next_s[0] = 1'b0;
  end

  // Run/halt FSM with registered ID_EX, branch redirect and halt outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ST_RUN;
      pending_r       <= {REG_COUNT{1'b0}};
      id_ex_r         <= ID_EX_IDLE;
      id_valid_r      <= 1'b0;
      branch_taken_r  <= 1'b0;
      branch_target_r <= 32'h0000_0000;
      halted_r        <= 1'b0;
    end else begin
      pending_r      <= pend_next_s;
      id_ex_r        <= ID_EX_IDLE;
      id_valid_r     <= 1'b0;
      branch_taken_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            case (op_s)
              OP_HLT: begin
                state_r  <= ST_HALT;
                halted_r <= 1'b1;
              end
              OP_BR: begin
                id_valid_r      <= 1'b1;
                branch_taken_r  <= 1'b1;
                branch_target_r <= target_s;
              end
              OP_BNE: begin
                id_valid_r      <= 1'b1;
                branch_taken_r  <= (rs_val_s != rt_val_s);
                branch_target_r <= target_s;
              end
              default: begin
                id_valid_r <= 1'b1;
                id_ex_r    <= pack_id_ex(if_pc, rs_val_s, rt_val_s, rd_s,
                                         imm16_s, op_norm_s, shamt_s);
              end
            endcase
          end
        end
        ST_HALT: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode and register-read stage; sits directly upstream of the execute stage and produces its 181-bit ID_EX bundle.
- Holds the 32x32 architectural register file, written from the writeback path.
- Tracks outstanding destination writes with a scoreboard and stalls fetch on RAW/WAW hazards.
- Resolves BR/BNE locally, and halts permanently on HLT until reset.

Parameters:
- REG_COUNT, 32, number of registers; fixed by the 5-bit address fields.
- DATA_W, 32, register and operand width.
- BNE_CHECK_HAZARD, 1, when 1, BNE waits for pending sources like any other consumer.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- if_ready  out  1  decode accepts this cycle (handshake = if_valid & if_ready).
- wb_en  in  1  register write strobe from writeback.
- wb_addr  in  5  write register index.
- wb_data  in  32  write data.
- id_ex  out  181  registered ID_EX bundle to execute.
- id_valid  out  1  id_ex holds a live instruction.
- branch_taken  out  1  one-cycle fetch redirect pulse.
- branch_target  out  32  redirect PC.
- halted  out  1  HLT has been decoded.

Behaviour:
- Instruction fields: [31:28] op, [27:23] rd, [22:18] rs, [17:13] rt, [12:0] imm13 (sign-extended to imm16), [4:0] shamt.
- id_ex layout:
  - [31:0] pc, [63:32] rs value, [95:64] rt value, [100:96] rd, [111:101] 0.
  - [127:112] imm16, [159:128] 0, [175:160] op zero-extended, [180:176] shamt.
- Opcodes: 1 ADD, 2 SUB, 3 LDI, 4 SHL, 5 SHR, 6 AND, 7 OR, 8 XOR, 9 BR, A BNE, B MOV, C ADI, D MUL, E HLT, F NOP; 0 is treated as NOP.
- Writers: ops 1-8, B, C, D, with rd != 0. All other ops are non-writers.
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - Write on clock when wb_en.
  - Same-cycle write and read of the same register returns wb_data (write-through bypass).
- Scoreboard pending[31:1]:
  - Set on issue of a writer.
  - Cleared on wb_en with matching wb_addr.
  - Simultaneous set and clear of the same register: set wins.
- Hazard: stall if pending[rs], pending[rt] or pending[rd] (for writers).
  - The check uses pending after the same-cycle clear, so writeback in cycle N unblocks issue in cycle N.
- if_ready = state==RUN & !hazard(if_instr) & !branch_taken.
- FSM:
  - RUN: on accept of E, go to HALT.
  - HALT: if_ready=0, halted=1, id_valid=0; exit only by reset.
- Issue timing:
  - An instruction accepted at edge N appears on id_ex with id_valid=1 after edge N (1-cycle latency).
  - In any cycle without an accept, id_valid=0 and id_ex[175:160]=16'hF; other id_ex fields are don't-care.
- BR: branch_taken=1 for the next cycle, branch_target = pc + sign-extended imm16; id_ex carries NOP.
- BNE: same as BR, but taken only if rs value != rt value; not-taken issues a NOP.
- During the branch_taken cycle if_ready=0; fetch must present the redirected stream afterwards.
- Reset:
  - Outputs: id_valid=0, id_ex=0 with op F, if_ready=0 in the reset cycle, branch_taken=0, halted=0.
  - State: pending cleared, state=RUN, all registers 0.
  - Reset mid-stall discards the held instruction (fetch re-presents).
- wb_en to an address whose pending bit is clear is legal and simply writes the register.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OP_ADD..OP_NOP);
  - ID_EX field offset/width constants;
  - an is_writer function.
- Execute must reuse the same constants.
- One natural sub-module: regfile_2r1w (two async read ports with write-through, one sync write, r0 hardwired).

Test Plan:
- Reset, then ADD r3,r1,r2 with r1=5, r2=7 preloaded via wb → next cycle id_valid=1, id_ex[63:32]=5, [95:64]=7, [100:96]=3, [175:160]=1.
- ADD r3 followed by SUB r4,r3,r1 → if_ready=0 until wb_en with addr 3; SUB issues in the same cycle as that wb, with id_ex[63:32]=wb_data.
- wb_en addr 0 data FFFF_FFFF, then MOV r5,r0 → id_ex[63:32]=0.
- BNE with r1=5, r2=7, pc=0x10, imm=0x4 → branch_taken=1 for one cycle, target=0x14, id_ex op F; with r1=r2 → no redirect.
- HLT accepted → halted=1 forever, if_ready=0, id_valid=0; reset asserted → halted=0, pending all clear.
- Issue a writer to r9 and wb to r9 in the same cycle → pending[9] stays 1; a second writer to r9 stalls (WAW).
